// File: rtl/alu_shift_stage.sv
// alu_shift_stage
// Post-ALU stage: captures the ALU result and carry-out, applies an optional
// iterative shift (one bit position per clock), then presents the result and
// the C/Z/N flags under a valid/ready handshake.
//
// Configuration macro: ALU_SHIFT_ROTATE_EN
//   defined   -> shop=11 is rotate-right
//   undefined -> shop=11 is arithmetic shift right (no rotate logic built)

module alu_shift_stage #(
   parameter int WIDTH = 16,
   parameter int CNTW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_cout,
   input  logic [1:0]       shop,
   input  logic [CNTW-1:0]  shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_SLL  = 2'b01;
   localparam logic [1:0] OP_SRL  = 2'b10;
   localparam logic [1:0] OP_SRA  = 2'b11;

   localparam logic [CNTW-1:0] CNT_ZERO = '0;
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] work_q;   // working register, also the visible result
   logic [1:0]       op_q;     // captured shift op
   logic [CNTW-1:0]  count_q;  // remaining shift steps
   logic             carry_q;  // carry flag: alu_cout, then last bit shifted out

   logic [WIDTH-1:0] step_res;
   logic             step_c;

   // One 1-bit shift step of the working register for the captured op.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      step_res = work_q;
      step_c   = carry_q;
      case (op_q)
         OP_SLL: begin
            step_res = {work_q[WIDTH-2:0], 1'b0};
            step_c   = work_q[WIDTH-1];
         end
         OP_SRL: begin
            step_res = {1'b0, work_q[WIDTH-1:1]};
            step_c   = work_q[0];
         end
         OP_SRA: begin
`ifdef ALU_SHIFT_ROTATE_EN
            step_res = {work_q[0], work_q[WIDTH-1:1]};
`else
            step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`endif
            step_c   = work_q[0];
         end
         default: begin
            step_res = work_q;
            step_c   = carry_q;
         end
      endcase
   end

   // Control FSM and datapath registers: accept in IDLE, shift in SHIFT, hold in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state   <= IDLE;
         work_q  <= '0;
         op_q    <= OP_PASS;
         count_q <= CNT_ZERO;
         carry_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work_q  <= alu_o;
                  op_q    <= shop;
                  carry_q <= alu_cout;
                  // Pass and zero-amount shifts skip SHIFT entirely so alu_cout is forwarded.
                  if ((shop == OP_PASS) || (shamt == CNT_ZERO)) begin
                     count_q <= CNT_ZERO;
                     state   <= DONE;
                  end else begin
                     count_q <= shamt;
                     state   <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_q  <= step_res;
               carry_q <= step_c;
               count_q <= count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // Result registers are untouched here, so they stay stable under backpressure.
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from state or taken straight from registers; no input-to-output paths.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign res       = work_q;
   assign flag_c    = carry_q;
   assign flag_n    = work_q[WIDTH-1];
   // Zero flag is qualified by DONE so it reads 0 out of reset even though work_q is 0.
   assign flag_z    = (state == DONE) && (work_q == '0);

endmodule
